// File: rtl/lut_seq_pkg.sv
// Shared types and helpers for the LUT layer sequencer.
package lut_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int unsigned NEURONS_DEFAULT = 16;
    localparam int unsigned FANIN_DEFAULT   = 8;
    localparam int unsigned TABLE_DEPTH     = NEURONS_DEFAULT << FANIN_DEFAULT;

    // Flat table address: neuron index in the upper bits, input pattern in the lower FANIN bits.
    function automatic logic [31:0] table_addr(input logic [31:0] neuron,
                                               input logic [31:0] pattern,
                                               input int unsigned fanin);
        return (neuron << fanin) | pattern;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table store: one write port, one registered read port, no reset on contents.
module lut_table_ram #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data
);

    logic mem_q [DEPTH];
    logic rd_data_q;

    // Synchronous write from the configuration side.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Synchronous read, data available the cycle after the address.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/lut_layer_sequencer.sv
// Evaluates a LogicNets layer one neuron per cycle through a single shared truth-table memory.
module lut_layer_sequencer
    import lut_seq_pkg::*;
#(
    parameter int unsigned NEURONS = NEURONS_DEFAULT,
    parameter int unsigned FANIN   = FANIN_DEFAULT,
    parameter int unsigned NIDX_W  = $clog2(NEURONS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [NIDX_W-1:0]          cfg_neuron,
    input  logic [FANIN-1:0]           cfg_addr,
    input  logic                       cfg_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NEURONS*FANIN-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NEURONS-1:0]         out_data,
    output logic                       busy
);

    localparam int unsigned ADDR_W = NIDX_W + FANIN;
    localparam int unsigned DEPTH  = NEURONS << FANIN;
    localparam int unsigned IN_W   = NEURONS * FANIN;

    state_e              state_q, state_d;
    logic [NIDX_W-1:0]   idx_q, idx_d;
    logic [IN_W-1:0]     in_reg_q, in_reg_d;
    logic [NEURONS-1:0]  out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    logic                in_accept;
    logic                wr_en;
    logic                rd_en;
    logic [FANIN-1:0]    rd_pattern;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic                rd_data;

    // in_ready_q is only ever high in IDLE, so it also qualifies the config port.
    assign in_accept = in_valid && in_ready_q;
    assign cfg_ready = in_ready_q && !in_valid;
    assign wr_en     = cfg_valid && cfg_ready;
    assign rd_en     = (state_q == RUN);

    // Address generation for both memory ports.
    always_comb begin
        rd_pattern = in_reg_q[idx_q*FANIN +: FANIN];
        rd_addr    = ADDR_W'(table_addr(32'(idx_q), 32'(rd_pattern), FANIN));
        wr_addr    = ADDR_W'(table_addr(32'(cfg_neuron), 32'(cfg_addr), FANIN));
    end

    lut_table_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (cfg_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_reg_d    = in_reg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_accept) begin
                    in_reg_d   = in_data;
                    idx_d      = '0;
                    out_data_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Read issued last cycle belongs to neuron idx-1.
                if (idx_q != '0) begin
                    out_data_d[idx_q - NIDX_W'(1)] = rd_data;
                end
                if (idx_q == NIDX_W'(NEURONS - 1)) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + NIDX_W'(1);
                end
            end
            DRAIN: begin
                out_data_d[NEURONS-1] = rd_data;
                out_valid_d           = 1'b1;
                state_d               = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            in_reg_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_reg_q    <= in_reg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Scoreboard bench for lut_layer_sequencer: directed vectors, monitor pops on output handshake.
module tb_lut_layer_sequencer;

    localparam int unsigned NEURONS = 16;
    localparam int unsigned FANIN   = 8;
    localparam int unsigned NIDX_W  = 4;
    localparam int unsigned IN_W    = NEURONS * FANIN;

    logic                clk;
    logic                rst_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [NIDX_W-1:0]   cfg_neuron;
    logic [FANIN-1:0]    cfg_addr;
    logic                cfg_data;
    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NEURONS-1:0]  out_data;
    logic                busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int hs_cyc = 0;
    int last_rise = 0;
    logic ov_prev = 1'b0;
    logic [NEURONS-1:0] exp_q [$];

    lut_layer_sequencer #(
        .NEURONS (NEURONS),
        .FANIN   (FANIN),
        .NIDX_W  (NIDX_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: track out_valid rise time and compare each accepted result with the queue head.
    initial begin
        logic [NEURONS-1:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && !ov_prev) last_rise = cyc;
            ov_prev = out_valid;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", 32'(out_data), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check(out_data == e, "result", 32'(out_data), 32'(e));
                end
            end
        end
    end

    task automatic cfg_write(input int n, input int a, input logic d);
        bit acc;
        acc = 1'b0;
        cfg_valid  = 1'b1;
        cfg_neuron = NIDX_W'(n);
        cfg_addr   = FANIN'(a);
        cfg_data   = d;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        if (!acc) check(1'b0, "cfg_timeout", 32'(0), 32'(1));
    endtask

    task automatic send_vec(input logic [IN_W-1:0] d, input logic [NEURONS-1:0] e, input bit push);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check(1'b0, "in_timeout", 32'(0), 32'(1));
        else begin
            hs_cyc = cyc;
            if (push) exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
        end
        @(posedge clk);
        #1;
        if (!done) check(1'b0, "drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    // Neuron n gets pattern (n + off) mod 256.
    function automatic logic [IN_W-1:0] patterns(input int off);
        logic [IN_W-1:0] v;
        v = '0;
        for (int n = 0; n < int'(NEURONS); n++) v[n*FANIN +: FANIN] = FANIN'(n + off);
        return v;
    endfunction

    initial begin
        logic [7:0] pa;
        bit stall_ok;
        bit hold_ok;
        bit seen;
        int stalls;

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'(0));
        check(out_data == '0, "rst_out_data", 32'(out_data), 32'(0));
        check(in_ready == 1'b0, "rst_in_ready", 32'(in_ready), 32'(0));
        check(cfg_ready == 1'b0, "rst_cfg_ready", 32'(cfg_ready), 32'(0));
        check(busy == 1'b0, "rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "idle_in_ready", 32'(in_ready), 32'(1));
        check(cfg_ready == 1'b1, "idle_cfg_ready", 32'(cfg_ready), 32'(1));
        check(busy == 1'b0, "idle_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // XOR tables on even neurons, AND tables on odd neurons; all-ones input
        for (int n = 0; n < int'(NEURONS); n++)
            for (int a = 0; a < 256; a++) begin
                pa = 8'(a);
                cfg_write(n, a, (n % 2 == 0) ? ^pa : &pa);
            end
        send_vec('1, 16'hAAAA, 1'b1);
        wait_done();
        check(last_rise - hs_cyc == 17, "latency", 32'(last_rise - hs_cyc), 32'(17));

        // Bit-0 identity tables
        for (int n = 0; n < int'(NEURONS); n++)
            for (int a = 0; a < 256; a++) cfg_write(n, a, a[0]);
        send_vec(patterns(0), 16'hAAAA, 1'b1);
        wait_done();
        send_vec(patterns(1), 16'h5555, 1'b1);
        wait_done();

        // Output held while out_ready is low
        out_ready = 1'b0;
        send_vec(patterns(0), 16'hAAAA, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check(seen, "hold_valid_seen", 32'(seen), 32'(1));
        hold_ok = 1'b1;
        for (int t = 0; t < 10; t++) begin
            if (!(out_valid && out_data == 16'hAAAA && !in_ready && busy)) hold_ok = 1'b0;
            @(negedge clk);
        end
        check(hold_ok, "hold_stable", 32'(hold_ok), 32'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(out_valid == 1'b0, "release_out_valid", 32'(out_valid), 32'(0));
        check(in_ready == 1'b1, "release_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;

        // Simultaneous config and input: input wins, write lands in next IDLE
        cfg_valid = 1'b1; cfg_neuron = 4'd0; cfg_addr = 8'h00; cfg_data = 1'b1;
        in_valid = 1'b1; in_data = patterns(0);
        @(negedge clk);
        check(cfg_ready == 1'b0, "collide_cfg_ready", 32'(cfg_ready), 32'(0));
        check(in_ready == 1'b1, "collide_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(16'hAAAA);
        stall_ok = 1'b1;
        stalls = 0;
        seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            seen = cfg_ready;
            if (!seen) begin
                stalls++;
                if (!busy) stall_ok = 1'b0;
            end
        end
        check(seen, "cfg_commit_seen", 32'(seen), 32'(1));
        check(stall_ok, "cfg_stall_only_busy", 32'(stall_ok), 32'(1));
        check(stalls == int'(NEURONS) + 2, "cfg_stall_cycles", 32'(stalls), 32'(NEURONS + 2));
        check(busy == 1'b0, "commit_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        send_vec(patterns(0), 16'hAAAB, 1'b1);
        wait_done();

        // Reset during RUN
        send_vec(patterns(1), 16'h0000, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check(out_valid == 1'b0, "midrst_out_valid", 32'(out_valid), 32'(0));
        check(busy == 1'b0, "midrst_busy", 32'(busy), 32'(0));
        check(in_ready == 1'b0, "midrst_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_vec(patterns(1), 16'h5555, 1'b1);
        wait_done();
        send_vec(patterns(0), 16'hAAAB, 1'b1);
        wait_done();

        // Single entry rewrite between identical all-zero inputs
        send_vec('0, 16'h0001, 1'b1);
        wait_done();
        cfg_write(3, 0, 1'b1);
        send_vec('0, 16'h0009, 1'b1);
        wait_done();

        check(exp_q.size() == 0, "queue_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
